// File: rtl/mod6_seq_ctrl.sv
// mod6_seq_ctrl: sequencer driving an external mod-6 counter.
//
// Commands (sampled on clk when ena=1):
//   IDLE priority is stop > load > start > step.
//   load  : one-cycle cnt_load pulse.
//   start : run the counter for run_wraps full wraps (0 = free-run).
//   step  : one single increment.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   ena              global enable; 0 freezes state, masks strobes
//   cmd_start/stop/step/load  level commands
//   load_val         counter preset (6/7 load as 0)
//   run_wraps        wraps to run, 0 = free-run
//   prescale         tick divider (prescaler build only)
//   cnt_in           current counter value
//   cnt_en, cnt_load, cnt_load_val  counter strobes and load data
//   busy, done       busy in RUN/STEP; done one-cycle pulse
//   wrap_cnt         wraps counted since the last start
//
// Build option: define MOD6_SEQ_CTRL_PRESCALE_EN to insert a 4-bit
// prescaler so RUN advances the counter every prescale+1 cycles.
// Without it the counter advances every RUN cycle and prescale is
// ignored.

module mod6_seq_ctrl #(
    parameter int WRAPS_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic               cmd_step,
    input  logic               cmd_load,
    input  logic [2:0]         load_val,
    input  logic [WRAPS_W-1:0] run_wraps,
    input  logic [3:0]         prescale,
    input  logic [2:0]         cnt_in,
    output logic               cnt_en,
    output logic               cnt_load,
    output logic [2:0]         cnt_load_val,
    output logic               busy,
    output logic               done,
    output logic [WRAPS_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    state_t             state;
    logic [WRAPS_W-1:0] wraps_lat;
    logic               load_q;
    logic               tick;
    logic               wrap;
    logic [WRAPS_W-1:0] wrap_inc;
    logic               term_wrap;

`ifdef MOD6_SEQ_CTRL_PRESCALE_EN
    logic [3:0] psc;
    logic [3:0] psc_lat;

    assign tick = (psc == psc_lat);
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign tick = 1'b1;
`endif

    assign busy   = (state == S_RUN) || (state == S_STEP);
    assign cnt_en = ena && (((state == S_RUN) && tick) ||
                            (state == S_STEP));

    // Out-of-range counter values (6/7) never register as a wrap.
    assign wrap = cnt_en && (cnt_in == 3'd5);

    assign wrap_inc = (&wrap_cnt) ? wrap_cnt
                                  : wrap_cnt + WRAPS_W'(1);

    // Terminal wrap: the one that brings wrap_cnt up to the target.
    assign term_wrap = wrap && (wraps_lat != '0) &&
                       (wrap_inc == wraps_lat);

    // The load strobe is masked directly by ena so a disable
    // during the pulse cycle suppresses it.
    assign cnt_load = load_q && ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wraps_lat    <= '0;
            load_q       <= 1'b0;
            cnt_load_val <= 3'd0;
            done         <= 1'b0;
            wrap_cnt     <= '0;
`ifdef MOD6_SEQ_CTRL_PRESCALE_EN
            psc          <= 4'd0;
            psc_lat      <= 4'd0;
`endif
        end else begin
            load_q <= 1'b0;
            if (ena) begin
                done <= 1'b0;
                if (wrap) begin
                    wrap_cnt <= wrap_inc;
                end
`ifdef MOD6_SEQ_CTRL_PRESCALE_EN
                if (state == S_RUN) begin
                    psc <= tick ? 4'd0 : psc + 4'd1;
                end
`endif
                unique case (state)
                    S_IDLE: begin
                        if (cmd_stop) begin
                            state <= S_IDLE;
                        end else if (cmd_load) begin
                            load_q       <= 1'b1;
                            cnt_load_val <= (load_val > 3'd5) ? 3'd0
                                                              : load_val;
                        end else if (cmd_start) begin
                            state     <= S_RUN;
                            wrap_cnt  <= '0;
                            wraps_lat <= run_wraps;
`ifdef MOD6_SEQ_CTRL_PRESCALE_EN
                            psc       <= 4'd0;
                            psc_lat   <= prescale;
`endif
                        end else if (cmd_step) begin
                            state <= S_STEP;
                        end
                    end
                    S_RUN: begin
                        // Stop beats a terminal wrap in the same cycle.
                        if (cmd_stop) begin
                            state <= S_IDLE;
                        end else if (term_wrap) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_STEP: begin
                        state <= S_IDLE;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod6_seq_ctrl.sv
// tb_mod6_seq_ctrl: scoreboard bench for mod6_seq_ctrl.
// Drives directed commands, models the external mod-6 counter.

module tb_mod6_seq_ctrl;

    localparam int WW = 4;

    localparam int EV_LOAD = 0;
    localparam int EV_DONE = 1;
    localparam int EV_FALL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          cmd_start = 1'b0;
    logic          cmd_stop = 1'b0;
    logic          cmd_step = 1'b0;
    logic          cmd_load = 1'b0;
    logic [2:0]    load_val = 3'd0;
    logic [WW-1:0] run_wraps = '0;
    logic [3:0]    prescale = 4'd0;
    logic [2:0]    cnt_in;
    logic          cnt_en;
    logic          cnt_load;
    logic [2:0]    cnt_load_val;
    logic          busy;
    logic          done;
    logic [WW-1:0] wrap_cnt;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  en_cnt = 0;
    logic prev_busy = 1'b0;

    mod6_seq_ctrl #(.WRAPS_W(WW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .cmd_start(cmd_start),
        .cmd_stop(cmd_stop),
        .cmd_step(cmd_step),
        .cmd_load(cmd_load),
        .load_val(load_val),
        .run_wraps(run_wraps),
        .prescale(prescale),
        .cnt_in(cnt_in),
        .cnt_en(cnt_en),
        .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val),
        .busy(busy),
        .done(done),
        .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    // External mod-6 counter model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_in <= 3'd0;
        else if (cnt_load) cnt_in <= cnt_load_val;
        else if (cnt_en) cnt_in <= (cnt_in == 3'd5) ? 3'd0 : cnt_in + 3'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        q.push_back(e);
    endtask

    task automatic consume(input int k, input int a, input int b);
        ev_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d a=%0d b=%0d expected none",
                     k, a, b);
        end else begin
            e = q.pop_front();
            chk("ev_kind", k, e.kind);
            chk((k == EV_LOAD) ? "load_val" :
                (k == EV_DONE) ? "done_wraps" : "fall_wraps", a, e.a);
            if (k == EV_FALL) chk("fall_en_cycles", b, e.b);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            en_cnt = 0;
        end else begin
            if (busy) en_cnt = (prev_busy ? en_cnt : 0) + int'(cnt_en);
            if (cnt_load) consume(EV_LOAD, int'(cnt_load_val), 0);
            if (done) consume(EV_DONE, int'(wrap_cnt), 0);
            if (prev_busy && !busy) consume(EV_FALL, int'(wrap_cnt), en_cnt);
            prev_busy = busy;
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] v, input int exp);
        expect_ev(EV_LOAD, exp, 0);
        cmd_load = 1'b1;
        load_val = v;
        step_clk();
        cmd_load = 1'b0;
    endtask

    task automatic start_run(input int wraps, input int psc);
        run_wraps = WW'(wraps);
        prescale = 4'(psc);
        cmd_start = 1'b1;
        step_clk();
        cmd_start = 1'b0;
    endtask

    // Last RUN cycle is the n-th after start_run returns.
    task automatic stop_after(input int n);
        repeat (n - 1) step_clk();
        cmd_stop = 1'b1;
        step_clk();
        cmd_stop = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            step_clk();
            t++;
        end
        step_clk();
        chk("scoreboard_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt_load", int'(cnt_load), 0);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_wrap_cnt", int'(wrap_cnt), 0);
        chk("rst_load_val", int'(cnt_load_val), 0);
        #5 rst_n = 1'b1;
        step_clk();

        // Loads: 7 and 6 map to 0.
        do_load(3'd7, 0);
        chk("load_busy", int'(busy), 0);
        do_load(3'd4, 4);
        do_load(3'd6, 0);
        step_clk();

        // Two wraps from 0: 12 cnt_en cycles then done.
        do_load(3'd0, 0);
        start_run(2, 0);
        repeat (6) step_clk();
        chk("run2_wrap1", int'(wrap_cnt), 1);
        expect_ev(EV_DONE, 2, 0);
        expect_ev(EV_FALL, 2, 12);
        wait_drain();
        chk("run2_idle", int'(busy), 0);

        // Free-run 100 cycles: saturate at 15, no done.
        do_load(3'd0, 0);
        start_run(0, 0);
        repeat (99) step_clk();
        chk("free_sat", int'(wrap_cnt), 15);
        expect_ev(EV_FALL, 15, 100);
        cmd_stop = 1'b1;
        step_clk();
        cmd_stop = 1'b0;
        chk("free_stop_busy", int'(busy), 0);
        wait_drain();

        // Clear wrap_cnt with a short run, then step on 5.
        do_load(3'd0, 0);
        start_run(0, 0);
        expect_ev(EV_FALL, 0, 3);
        stop_after(3);
        do_load(3'd5, 5);
        expect_ev(EV_FALL, 1, 1);
        cmd_step = 1'b1;
        step_clk();
        cmd_step = 1'b0;
        wait_drain();
        chk("step_wrap_hold", int'(wrap_cnt), 1);

        // Stop in the terminal-wrap cycle: IDLE, no done.
        do_load(3'd4, 4);
        start_run(1, 0);
        expect_ev(EV_FALL, 1, 2);
        stop_after(2);
        wait_drain();

        // ena=0 after first wrap freezes everything.
        do_load(3'd0, 0);
        start_run(2, 0);
        repeat (7) step_clk();
        ena = 1'b0;
        step_clk();
        chk("frz_cnt_en", int'(cnt_en), 0);
        chk("frz_busy", int'(busy), 1);
        repeat (3) step_clk();
        chk("frz_wrap_cnt", int'(wrap_cnt), 1);
        step_clk();
        ena = 1'b1;
        expect_ev(EV_DONE, 2, 0);
        expect_ev(EV_FALL, 2, 12);
        wait_drain();

        // Prescale=2, run_wraps=1.
        do_load(3'd0, 0);
        start_run(1, 2);
`ifdef MOD6_SEQ_CTRL_PRESCALE_EN
        chk("psc_first_idle", int'(cnt_en), 0);
        step_clk();
        step_clk();
        chk("psc_first_tick", int'(cnt_en), 1);
`else
        chk("psc_ignored", int'(cnt_en), 1);
`endif
        expect_ev(EV_DONE, 1, 0);
        expect_ev(EV_FALL, 1, 6);
        wait_drain();

        // Async reset mid-run.
        do_load(3'd0, 0);
        start_run(0, 0);
        repeat (7) step_clk();
        chk("pre_rst_wrap", int'(wrap_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_cnt_en", int'(cnt_en), 0);
        chk("arst_wrap_cnt", int'(wrap_cnt), 0);
        #3 rst_n = 1'b1;
        step_clk();

        // Priorities in IDLE.
        do_load(3'd3, 3);
        expect_ev(EV_LOAD, 2, 0);
        cmd_load = 1'b1;
        cmd_start = 1'b1;
        load_val = 3'd2;
        step_clk();
        cmd_load = 1'b0;
        cmd_start = 1'b0;
        chk("load_over_start", int'(busy), 0);
        cmd_stop = 1'b1;
        cmd_load = 1'b1;
        step_clk();
        cmd_stop = 1'b0;
        cmd_load = 1'b0;
        chk("stop_over_load", int'(cnt_load), 0);
        expect_ev(EV_FALL, 0, 3);
        cmd_start = 1'b1;
        cmd_step = 1'b1;
        run_wraps = '0;
        step_clk();
        cmd_start = 1'b0;
        cmd_step = 1'b0;
        stop_after(3);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod6_seq_ctrl.md
MOD6_SEQ_CTRL -- requirements
Module: mod6_seq_ctrl

Interface
REQ-001 SHALL have parameter WRAPS_W, default 4, width of run_wraps and wrap_cnt.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  global enable; 0 freezes all state and forces cnt_en=0, cnt_load=0.
REQ-005 SHALL have ports cmd_start, cmd_stop, cmd_step, cmd_load  input  1 each  level commands sampled at clk edge.
REQ-006 SHALL have port load_val  input  3  preset for counter.
REQ-007 SHALL have port run_wraps  input  WRAPS_W  full wraps to run; 0 = free-run.
REQ-008 SHALL have port prescale  input  4  tick divider (used only per REQ-029).
REQ-009 SHALL have port cnt_in  input  3  current mod-6 counter value.
REQ-010 SHALL have ports cnt_en, cnt_load  output  1 each  counter increment / load strobes.
REQ-011 SHALL have port cnt_load_val  output  3  load data.
REQ-012 SHALL have ports busy, done  output  1 each  busy level; done single-cycle pulse.
REQ-013 SHALL have port wrap_cnt  output  WRAPS_W  wraps counted since last start.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, STEP, DONE; commands evaluated only when ena=1.
REQ-015 SHALL, in IDLE, apply priority stop > load > start > step; stop in IDLE is a no-op.
REQ-016 SHALL, on cmd_load in IDLE, register cnt_load=1 for exactly one cycle with cnt_load_val=load_val, mapping 6 and 7 to 0; state stays IDLE.
REQ-017 SHALL, on cmd_start in IDLE, enter RUN next cycle, clear wrap_cnt, latch run_wraps and prescale.
REQ-018 SHALL, on cmd_step in IDLE, enter STEP for exactly one cycle, then IDLE.
REQ-019 SHALL drive cnt_en = ena and ((RUN and tick) or STEP), combinational from registered state.
REQ-020 SHALL define wrap = cnt_en and cnt_in==5; cnt_in 6/7 never count as wrap.
REQ-021 SHALL increment wrap_cnt by 1 on each wrap, saturating at 2^WRAPS_W-1.
REQ-022 SHALL, in RUN with latched run_wraps != 0, go to DONE on the wrap making wrap_cnt equal run_wraps.
REQ-023 SHALL, on cmd_stop in RUN, return to IDLE next cycle; wrap_cnt retained; a wrap in the stop cycle still counts; stop in the terminal-wrap cycle wins (IDLE, no done).
REQ-024 SHALL ignore cmd_load, cmd_start, cmd_step while in RUN, STEP or DONE.
REQ-025 SHALL, in DONE, assert done=1 for one cycle, then IDLE.
REQ-026 SHALL assert busy=1 exactly in RUN and STEP.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-RUN, asynchronously force IDLE, cnt_load=0, cnt_load_val=0, done=0, wrap_cnt=0, prescaler=0, latched registers=0; cnt_en=0 and busy=0 follow.
REQ-028 SHALL resume command sampling on the first clk edge after rst_n rises.

Configuration
REQ-029 SHALL, with MOD6_SEQ_CTRL_PRESCALE_EN defined, generate tick when a 4-bit prescaler cleared on start equals latched prescale, then clear it (tick every prescale+1 cycles in RUN, first tick prescale+1 cycles after entering RUN; prescale=0 gives every cycle).
REQ-030 SHALL, without MOD6_SEQ_CTRL_PRESCALE_EN, hold tick=1 constantly, ignore prescale and omit the prescaler register.

Verification
REQ-031 SHALL cover: reset, cmd_load with load_val=7 -> one cnt_load pulse, cnt_load_val=0, busy=0.
REQ-032 SHALL cover: counter at 0, run_wraps=2, cmd_start, no prescale -> cnt_en high 12 cycles, wrap_cnt 1 then 2, done pulse one cycle after 2nd wrap, then IDLE.
REQ-033 SHALL cover: run_wraps=0 free-run 100 cycles with WRAPS_W=4 -> wrap_cnt saturates at 15, no done; cmd_stop -> busy=0 next cycle.
REQ-034 SHALL cover: cmd_step with cnt_in=5 -> single cnt_en cycle, wrap_cnt increments by 1, back to IDLE.
REQ-035 SHALL cover: with macro, prescale=2, run_wraps=1 -> cnt_en every 3rd cycle, done after 18 cycles; ena=0 mid-run freezes prescaler and wrap_cnt.
REQ-036 SHALL cover: rst_n low mid-RUN -> busy, cnt_en, wrap_cnt go 0 without a clk edge.
